// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state type, line levels,
// default bit timing and an even-parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    // Matches the receiver's per-bit timer.
    localparam int UART_DEFAULT_CLKS_PER_BIT = 10;

    // XOR of the low nbits of data; upper bits are ignored so 5..8 bit frames share it.
    function automatic logic even_parity(input logic [7:0] data, input int nbits);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_timer.sv
// Baud and bit counters for uart_tx: bit_strobe marks the last cycle of each serial bit,
// pre_strobe the cycle before it, bits_done the strobe that ends the final data bit.
module uart_tx_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic count_bits,
    output logic bit_strobe,
    output logic pre_strobe,
    output logic bits_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic [CNT_W-1:0] baud_cnt;
    logic [BIT_W-1:0] bit_cnt;

    assign bit_strobe = enable && (baud_cnt == CNT_LAST);
    assign pre_strobe = enable && (baud_cnt == CNT_PRE);
    assign bits_done  = bit_strobe && count_bits && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (enable) begin
            if (baud_cnt == CNT_LAST) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
            // Bit counter only advances on data-bit strobes and wraps once the byte is out.
            if (bit_strobe && count_bits) begin
                if (bits_done) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS data bits LSB-first, optional even parity
// (UART_TX_PARITY_EN), stop. All outputs are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready; tx_valid
    // and tx_data are don't-care while tx_ready is low, and tx_ready only rises in IDLE.

    uart_tx_state_t       state;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 handshake;
    logic                 bit_strobe;
    logic                 pre_strobe;
    logic                 bits_done;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign handshake = tx_valid && tx_ready;

    uart_tx_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .enable     (state != IDLE),
        .clear      (handshake),
        .count_bits (state == DATA),
        .bit_strobe (bit_strobe),
        .pre_strobe (pre_strobe),
        .bits_done  (bits_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= UART_IDLE_LEVEL;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            shift_reg  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    serial_out <= UART_IDLE_LEVEL;
                    if (handshake) begin
                        shift_reg  <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= even_parity(8'(tx_data), DATA_BITS);
`endif
                        state      <= START;
                        serial_out <= UART_START_LEVEL;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_strobe) begin
                        state      <= DATA;
                        serial_out <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_strobe) begin
                        shift_reg <= shift_reg >> 1;
                        if (bits_done) begin
`ifdef UART_TX_PARITY_EN
                            state      <= PARITY;
                            serial_out <= parity_bit;
`else
                            state      <= STOP;
                            serial_out <= UART_STOP_LEVEL;
`endif
                        end else begin
                            // Next bit is already sitting one place up in the shifter.
                            serial_out <= shift_reg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_strobe) begin
                        state      <= STOP;
                        serial_out <= UART_STOP_LEVEL;
                    end
                end
`endif
                STOP: begin
                    // Registered tx_done must be raised one cycle early to land on the strobe cycle.
                    if (pre_strobe) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_strobe) begin
                        state      <= IDLE;
                        serial_out <= UART_IDLE_LEVEL;
                        tx_ready   <= 1'b1;
                        tx_busy    <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= UART_IDLE_LEVEL;
                    tx_ready   <= 1'b1;
                    tx_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset/idle, single frame, back-to-back frames,
// mid-frame data change, mid-frame reset, parity frame when UART_TX_PARITY_EN is set.
module tb_uart_tx;

    localparam int CPB = 10;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = DB + 3;
`else
    localparam int FRAME_BITS = DB + 2;
`endif

    logic          clk;
    logic          rst;
    logic          tx_valid;
    logic [DB-1:0] tx_data;
    logic          tx_ready;
    logic          serial_out;
    logic          tx_busy;
    logic          tx_done;

    int checks;
    int failures;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_idle(input string tag);
        check({tag, " serial_out"}, 32'(serial_out), 32'd1);
        check({tag, " tx_ready"},   32'(tx_ready),   32'd1);
        check({tag, " tx_busy"},    32'(tx_busy),    32'd0);
        check({tag, " tx_done"},    32'(tx_done),    32'd0);
    endtask

    // Called on the first cycle of the start bit; returns on the last stop cycle.
    task automatic frame_check(input logic [7:0] d, input int change_at,
                               input logic [7:0] new_data, input string tag);
        int   total;
        logic lvl;
        total = FRAME_BITS * CPB;
        for (int k = 0; k < total; k++) begin
            int b;
            b = k / CPB;
            if (b == 0) lvl = 1'b0;
            else if (b <= DB) lvl = d[b-1];
            else if (b == FRAME_BITS - 1) lvl = 1'b1;
            else lvl = ^d;
            if (k == change_at) tx_data = new_data;
            check($sformatf("%s k=%0d serial_out", tag, k), 32'(serial_out), 32'(lvl));
            check($sformatf("%s k=%0d tx_done", tag, k), 32'(tx_done), 32'(k == total - 1));
            check($sformatf("%s k=%0d tx_ready", tag, k), 32'(tx_ready), 32'd0);
            check($sformatf("%s k=%0d tx_busy", tag, k), 32'(tx_busy), 32'd1);
            if (k != total - 1) tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        tick();
        tick();
        tick();
        expect_idle("reset");
        rst = 1'b0;

        // Idle line for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_idle($sformatf("idle c%0d", i));
        end

        // Single frame 0xA5: line 0,1,0,1,0,0,1,0,1,1; done on cycle 100.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        frame_check(8'hA5, -1, 8'h00, "a5");
        tick();
        expect_idle("a5 post");

        // Back-to-back 0x00 then 0xFF with tx_valid held; new data written mid-frame.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'hFF;
        frame_check(8'h00, -1, 8'h00, "b2b0");
        tick();
        expect_idle("b2b gap");
        tick();
        tx_valid = 1'b0;
        frame_check(8'hFF, -1, 8'h00, "b2b1");
        tick();
        expect_idle("b2b post");

        // 0x3C with tx_data switched to 0xC3 during data bit 2.
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        frame_check(8'h3C, 3 * CPB, 8'hC3, "3c");
        tick();
        expect_idle("3c post");

        // Reset in the middle of data bit 3 of 0x96 (bit 3 = 0).
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 4 * CPB + 3; i++) tick();
        check("rst pre serial_out", 32'(serial_out), 32'd0);
        check("rst pre tx_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_idle("rst post");
        for (int i = 0; i < 7 * CPB; i++) begin
            tick();
            expect_idle($sformatf("rst quiet c%0d", i));
        end

        // 0x07: parity bit 1 (when enabled); done 110 cycles after start, else 100.
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        frame_check(8'h07, -1, 8'h00, "07");
        tick();
        expect_idle("07 post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter; the transmit-side counterpart of the existing UART receive path.
- Accepts one byte per valid/ready handshake and serialises it LSB-first on serial_out.
- Frame format: start bit (0), 8 data bits, optional even-parity bit, stop bit (1).
- Every bit is held for CLKS_PER_BIT clock cycles. The default of 10 matches the receiver's per-bit timer.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit; legal range >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
tx_valid  input  1  producer has a byte on tx_data.
tx_data  input  DATA_BITS  byte to transmit; sampled only on handshake.
tx_ready  output  1  block is idle and can accept a byte.
serial_out  output  1  UART line; idles high.
tx_busy  output  1  a frame is in progress (start, data, parity or stop).
tx_done  output  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Reset: rst=1 on a clk edge forces the following, next cycle:
  - state=IDLE, serial_out=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Baud counter=0, bit counter=0, shift register=0.
- Reset mid-frame aborts the frame immediately. The line returns high the cycle after the reset edge. No tx_done is produced.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - tx_ready=1, serial_out=1.
  - Handshake = tx_valid && tx_ready. On handshake, latch tx_data into the shift register and go to START.
  - The next cycle shows serial_out=0, tx_ready=0 and tx_busy=1.
- Baud timer: counts 0..CLKS_PER_BIT-1 while in START/DATA/PARITY/STOP.
  - bit_strobe is asserted on count CLKS_PER_BIT-1, then the counter wraps to 0.
  - Counter width is $clog2(CLKS_PER_BIT).
- START: serial_out=0 for CLKS_PER_BIT cycles; on bit_strobe, go to DATA.
- DATA:
  - serial_out = shift register bit 0.
  - On each bit_strobe, shift right and increment the bit counter.
  - After DATA_BITS strobes, go to PARITY if enabled, otherwise STOP.
- STOP:
  - serial_out=1 for CLKS_PER_BIT cycles.
  - tx_done=1 on the cycle where bit_strobe=1. The next cycle is IDLE with tx_ready=1.
- Frame timing:
  - Start-bit low time to the end of stop = (DATA_BITS+2)*CLKS_PER_BIT cycles, or (DATA_BITS+3)*CLKS_PER_BIT with parity.
  - Back-to-back: if tx_valid is held high, the next byte is accepted in the first IDLE cycle. This gives exactly 1 idle-high cycle between stop and the next start.
- tx_data and tx_valid are ignored while tx_ready=0. Changes to tx_data mid-frame do not affect the frame in flight.
- tx_busy is the inverse of tx_ready in all states except reset. In reset, tx_ready=1 and tx_busy=0.
- tx_done never coincides with tx_ready=1.

Optional Feature:
Macro: UART_TX_PARITY_EN
- Defined:
  - PARITY state is inserted between DATA and STOP for CLKS_PER_BIT cycles.
  - serial_out = XOR of the latched data bits (even parity).
  - The parity value is computed at handshake and stored.
- Undefined: PARITY state and the parity register are absent; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum type uart_tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - constants UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0, UART_STOP_LEVEL=1'b1;
  - the default CLKS_PER_BIT value.
- One sub-module is natural: uart_tx_timer.
  - Contains the baud counter and bit counter.
  - Inputs: clk, rst, enable, clear.
  - Outputs: bit_strobe, and bits_done after DATA_BITS strobes.

Test Plan:
1. Reset, then hold idle 20 cycles -> serial_out=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
2. Send 0xA5 with CLKS_PER_BIT=10, no parity:
   - Line sequence, each level held 10 cycles: 0, then data 1,0,1,0,0,1,0,1, then 1.
   - tx_done pulses exactly on cycle 100 after the start bit begins.
   - tx_ready=1 the following cycle.
3. Hold tx_valid high for bytes 0x00 then 0xFF:
   - Second start bit begins exactly 1 cycle after the first frame's tx_done.
   - Data bits of the second frame are all 1.
4. Change tx_data from 0x3C to 0xC3 during DATA of a 0x3C frame -> transmitted bits remain 0,0,1,1,1,1,0,0.
5. Assert rst for 1 cycle during data bit 3 -> the next cycle shows serial_out=1, tx_ready=1, and no tx_done.
6. Set UART_TX_PARITY_EN and send 0x07:
   - Parity bit = 1, held 10 cycles, between data bit 7 and stop.
   - tx_done arrives 110 cycles after the start bit begins.
